mem_bridge: RTL
===============

Name: mem_bridge

Overview:
- Sits directly downstream of the cpu top's memory port, between the core's memory-request signals and a fixed-latency synchronous word RAM.
- Accepts one word read or write per request and drives the RAM chip-select, write-enable, address and data.
- Counts out the RAM latency and returns read data with a one-cycle acknowledge.
- Turns the core's raw memory accesses into a clean stall/ack handshake and flags misaligned addresses.

Parameters:
- RAM_LATENCY, 2, cycles from the ram_cs_o cycle to valid ram_rdata_i; legal range 1..15.
- ADDR_W, 16, RAM word-address width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- cpu_req_i  in  1  request strobe; sampled only in IDLE.
- cpu_we_i  in  1  1 = write, 0 = read.
- cpu_addr_i  in  32  byte address; must be word aligned.
- cpu_wdata_i  in  32  write data.
- cpu_rdata_o  out  32  read data; held until the next read completes.
- cpu_ack_o  out  1  one-cycle completion pulse.
- cpu_err_o  out  1  misalignment flag; valid while cpu_ack_o is high.
- cpu_busy_o  out  1  high in every state except IDLE.
- ram_cs_o  out  1  RAM chip select; one-cycle pulse per access.
- ram_we_o  out  1  RAM write enable; qualified by ram_cs_o.
- ram_addr_o  out  ADDR_W  word address, cpu_addr_i[ADDR_W+1:2].
- ram_wdata_o  out  32  RAM write data.
- ram_rdata_i  in  32  RAM read data.

Behaviour:
- Reset asserted (low) at any time, including mid-access:
  - all outputs go to 0 immediately and the FSM returns to IDLE;
  - the in-flight access is abandoned with no ack;
  - latched address/data and cpu_rdata_o are cleared to 0.
- All outputs are registered. States: IDLE, ISSUE, WAIT, ACK.
- IDLE, cpu_req_i=1 at edge N:
  - latch we, addr and wdata;
  - if addr[1:0]!=0: go to ACK with cpu_err_o=1 and no RAM access;
  - otherwise go to ISSUE.
- ISSUE (cycle N+1):
  - ram_cs_o=1, ram_we_o=latched we, ram_addr_o and ram_wdata_o driven;
  - load the counter with RAM_LATENCY-1 and go to WAIT.
- WAIT:
  - ram_cs_o=0 and ram_addr_o/ram_wdata_o held;
  - decrement the counter;
  - when the counter is 0, capture ram_rdata_i into cpu_rdata_o at that edge (reads only) and go to ACK.
- ACK: cpu_ack_o=1 for exactly one cycle, then return to IDLE.
- Latency:
  - aligned access: request edge to ack = RAM_LATENCY+2 cycles;
  - misaligned access: 1 cycle.
- Writes:
  - cpu_rdata_o is unchanged;
  - the write is complete by the ack.
- Requests arriving in ISSUE, WAIT or ACK are ignored, not queued; the core must re-present the request when cpu_busy_o=0.
  - A request held high through ACK is accepted on the first IDLE cycle (back-to-back spacing RAM_LATENCY+3 cycles).
- cpu_err_o is 0 whenever cpu_ack_o is 0.
- Counter width is 4 bits; there is no wrap beyond RAM_LATENCY.

Optional Feature:
- Macro: MEM_BRIDGE_READ_BYPASS_EN.
- Enabled: a one-entry tag register holds the word address and data of the last completed read, plus a valid bit.
  - Aligned read hitting a valid tag: IDLE goes straight to ACK (ack 1 cycle after request) with the stored data and no ram_cs_o.
  - Any write to the tagged address clears the valid bit.
  - Reset clears the valid bit.
- Disabled: every aligned access goes through the RAM; no tag logic is synthesized.

Decomposition:
- Shared package:
  - FSM state enum (IDLE/ISSUE/WAIT/ACK);
  - word-size constant 32;
  - alignment-mask constant 2'b11.
- One natural sub-module: mem_bridge_bypass (tag register, valid bit and compare), instantiated only under the macro.

Test Plan:
- Read, RAM_LATENCY=2, RAM word 4 = 0xDEADBEEF, req with addr 0x10 at edge 0:
  - ram_cs_o=1 with ram_addr_o=4 in cycle 1;
  - cpu_ack_o=1 in cycle 4 with cpu_rdata_o=0xDEADBEEF and cpu_err_o=0.
- Write 0x12345678 to 0x20, then read 0x20:
  - cs/we=1, addr 8 in cycle 1, ack in cycle 4;
  - the read returns 0x12345678;
  - cpu_rdata_o is unchanged during the write's ack.
- Misaligned read of 0x13:
  - ack and err=1 in cycle 1;
  - ram_cs_o never asserted;
  - cpu_rdata_o unchanged.
- cpu_req_i held high continuously:
  - accesses accepted every 5 cycles;
  - exactly one ram_cs_o pulse per access;
  - mid-access requests ignored.
- Reset pulled low during WAIT:
  - all outputs 0 immediately, no ack;
  - after release, a fresh read of 0x10 completes normally.
- With MEM_BRIDGE_READ_BYPASS_EN:
  - repeat the read of 0x10: ack in cycle 1, no cs, same data;
  - then write 0x10 and read 0x10: the read goes to RAM with the full 4-cycle latency.

Source files
------------

// File: rtl/mem_bridge_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mem_bridge_pkg
//  Purpose  : Shared types and constants for the CPU-to-word-RAM bridge:
//             FSM state encoding, data word width, counter width and the
//             byte-offset mask used for alignment checks.
//  Revision : 1.0  initial release
// ============================================================================
package mem_bridge_pkg;

    localparam int         c_word_w     = 32;
    localparam int         c_cnt_w      = 4;
    localparam logic [1:0] c_align_mask = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_ACK   = 2'd3
    } state_t;

    // A byte address is misaligned when any of its byte-offset bits is set.
    function automatic logic is_misaligned(input logic [1:0] byte_off);
        return (byte_off & c_align_mask) != 2'b00;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_bridge_if.sv
`default_nettype none
// ============================================================================
//  Module   : mem_bridge_if
//  Purpose  : Bundles the CPU request/response signals and the RAM port of
//             the memory bridge. The slave modport is the bridge itself; the
//             master modport is its environment (core plus RAM).
//  Revision : 1.0  initial release
// ============================================================================
interface mem_bridge_if #(
    parameter int ADDR_W = 16
);
    import mem_bridge_pkg::*;

    // CPU side
    logic                cpu_req_i;
    logic                cpu_we_i;
    logic [c_word_w-1:0] cpu_addr_i;
    logic [c_word_w-1:0] cpu_wdata_i;
    logic [c_word_w-1:0] cpu_rdata_o;
    logic                cpu_ack_o;
    logic                cpu_err_o;
    logic                cpu_busy_o;

    // RAM side
    logic                ram_cs_o;
    logic                ram_we_o;
    logic [ADDR_W-1:0]   ram_addr_o;
    logic [c_word_w-1:0] ram_wdata_o;
    logic [c_word_w-1:0] ram_rdata_i;

    modport slave (
        input  cpu_req_i, cpu_we_i, cpu_addr_i, cpu_wdata_i, ram_rdata_i,
        output cpu_rdata_o, cpu_ack_o, cpu_err_o, cpu_busy_o,
        output ram_cs_o, ram_we_o, ram_addr_o, ram_wdata_o
    );

    modport master (
        output cpu_req_i, cpu_we_i, cpu_addr_i, cpu_wdata_i, ram_rdata_i,
        input  cpu_rdata_o, cpu_ack_o, cpu_err_o, cpu_busy_o,
        input  ram_cs_o, ram_we_o, ram_addr_o, ram_wdata_o
    );

endinterface
`default_nettype wire

// File: rtl/mem_bridge_bypass.sv
`default_nettype none
// ============================================================================
//  Module   : mem_bridge_bypass
//  Purpose  : One-entry read tag (word address, data, valid) that lets a
//             repeated read of the last completed read address skip the RAM.
//             Only compiled when MEM_BRIDGE_READ_BYPASS_EN is defined, so the
//             default build carries no tag logic at all.
//  Revision : 1.0  initial release
// ============================================================================
`ifdef MEM_BRIDGE_READ_BYPASS_EN
module mem_bridge_bypass
    import mem_bridge_pkg::*;
#(
    parameter int ADDR_W = 16
) (
    input  wire logic                clk,
    input  wire logic                reset,          // asynchronous, active-low
    input  wire logic [ADDR_W-1:0]   i_lookup_addr,
    input  wire logic                i_fill_en,
    input  wire logic [ADDR_W-1:0]   i_fill_addr,
    input  wire logic [c_word_w-1:0] i_fill_data,
    input  wire logic                i_inval_en,
    input  wire logic [ADDR_W-1:0]   i_inval_addr,
    output logic                     o_hit,
    output logic [c_word_w-1:0]      o_data
);

    logic                r_valid;
    logic [ADDR_W-1:0]   r_tag;
    logic [c_word_w-1:0] r_data;

    // Capture each completed RAM read; drop the entry when its word is written.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_valid <= 1'b0;
            r_tag   <= '0;
            r_data  <= '0;
        end else if (i_fill_en) begin
            r_valid <= 1'b1;
            r_tag   <= i_fill_addr;
            r_data  <= i_fill_data;
        end else if (i_inval_en && (i_inval_addr == r_tag)) begin
            r_valid <= 1'b0;
        end
    end

    assign o_hit  = r_valid && (r_tag == i_lookup_addr);
    assign o_data = r_data;

endmodule
`endif
`default_nettype wire

// File: rtl/mem_bridge.sv
`default_nettype none
// ============================================================================
//  Module   : mem_bridge
//  Purpose  : Converts single-word CPU read/write requests into accesses to a
//             fixed-latency synchronous word RAM, returning a one-cycle ack
//             and flagging misaligned byte addresses without touching RAM.
//             Optional read bypass (one-entry tag) under the macro
//             MEM_BRIDGE_READ_BYPASS_EN.
//  Revision : 1.0  initial release
// ============================================================================
module mem_bridge
    import mem_bridge_pkg::*;
#(
    parameter int RAM_LATENCY = 2,   // cycles from ram_cs_o to valid read data, 1..15
    parameter int ADDR_W      = 16   // RAM word-address width
) (
    input  wire logic    clk,
    input  wire logic    reset,      // asynchronous, active-low
    mem_bridge_if.slave  bus
);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [c_cnt_w-1:0]    r_cnt;

    logic                  r_we;
    logic [ADDR_W-1:0]     r_addr;
    logic [c_word_w-1:0]   r_wdata;
    logic [c_word_w-1:0]   r_rdata;

    logic                  r_ack;
    logic                  r_err;
    logic                  r_busy;
    logic                  r_cs;
    logic                  r_ram_we;

    logic                  w_accept;
    logic                  w_misaligned;
    logic [ADDR_W-1:0]     w_req_word;
    logic                  w_rd_done;
    logic                  w_hit;
    logic [c_word_w-1:0]   w_hit_data;

    logic                  w_ack_d;
    logic                  w_err_d;
    logic                  w_busy_d;
    logic                  w_cs_d;
    logic                  w_ram_we_d;

    assign w_accept     = (r_state == ST_IDLE) && bus.cpu_req_i;
    assign w_misaligned = is_misaligned(bus.cpu_addr_i[1:0]);
    assign w_req_word   = bus.cpu_addr_i[ADDR_W+1:2];
    assign w_rd_done    = (r_state == ST_WAIT) && (r_cnt == '0);

`ifdef MEM_BRIDGE_READ_BYPASS_EN
    logic w_tag_hit;

    mem_bridge_bypass #(
        .ADDR_W (ADDR_W)
    ) u_bypass (
        .clk           (clk),
        .reset         (reset),
        .i_lookup_addr (w_req_word),
        .i_fill_en     (w_rd_done && !r_we),
        .i_fill_addr   (r_addr),
        .i_fill_data   (bus.ram_rdata_i),
        .i_inval_en    (w_accept && bus.cpu_we_i && !w_misaligned),
        .i_inval_addr  (w_req_word),
        .o_hit         (w_tag_hit),
        .o_data        (w_hit_data)
    );

    // Only an aligned read may be served from the tag.
    assign w_hit = w_accept && !bus.cpu_we_i && !w_misaligned && w_tag_hit;
`else
    assign w_hit      = 1'b0;
    assign w_hit_data = '0;
`endif

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: misaligned requests and tag hits skip the RAM entirely.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (bus.cpu_req_i) begin
                    if (w_misaligned || w_hit) begin
                        w_state_nxt = ST_ACK;
                    end else begin
                        w_state_nxt = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: w_state_nxt = ST_WAIT;
            ST_WAIT: begin
                if (r_cnt == '0) begin
                    w_state_nxt = ST_ACK;
                end
            end
            ST_ACK:   w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Output decode from the upcoming state so every output leaves a flop.
    always_comb begin
        w_ack_d    = (w_state_nxt == ST_ACK);
        w_err_d    = w_accept && w_misaligned;
        w_busy_d   = (w_state_nxt != ST_IDLE);
        w_cs_d     = (w_state_nxt == ST_ISSUE);
        // ISSUE is only entered from an IDLE accept, so the live we is the one latched.
        w_ram_we_d = (w_state_nxt == ST_ISSUE) && bus.cpu_we_i;
    end

    // Output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ack    <= 1'b0;
            r_err    <= 1'b0;
            r_busy   <= 1'b0;
            r_cs     <= 1'b0;
            r_ram_we <= 1'b0;
        end else begin
            r_ack    <= w_ack_d;
            r_err    <= w_err_d;
            r_busy   <= w_busy_d;
            r_cs     <= w_cs_d;
            r_ram_we <= w_ram_we_d;
        end
    end

    // Latch the request on acceptance; RAM address and data hold until the next one.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (w_accept) begin
            r_we    <= bus.cpu_we_i;
            r_addr  <= w_req_word;
            r_wdata <= bus.cpu_wdata_i;
        end
    end

    // Latency counter: loaded in ISSUE, counts down to zero in WAIT.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (r_state == ST_ISSUE) begin
            r_cnt <= c_cnt_w'(RAM_LATENCY - 1);
        end else if ((r_state == ST_WAIT) && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    // Read data holds until the next read completes, from RAM or from the tag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rdata <= '0;
        end else if (w_rd_done && !r_we) begin
            r_rdata <= bus.ram_rdata_i;
        end else if (w_hit) begin
            r_rdata <= w_hit_data;
        end
    end

    assign bus.cpu_rdata_o = r_rdata;
    assign bus.cpu_ack_o   = r_ack;
    assign bus.cpu_err_o   = r_err;
    assign bus.cpu_busy_o  = r_busy;
    assign bus.ram_cs_o    = r_cs;
    assign bus.ram_we_o    = r_ram_we;
    assign bus.ram_addr_o  = r_addr;
    assign bus.ram_wdata_o = r_wdata;

endmodule
`default_nettype wire
